fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface. Owns the program counter, drives the fetch address, and captures the returned word every cycle.
- Fetched words sit in a small FIFO, each tagged with its PC and a fault flag. Decode drains them through a valid/ready handshake.
- Sits between instruction memory (combinational, little-endian, byte-addressed, window 0xBFC00000–0xBFC00FFF) and the decode stage. Accepts branch/jump redirects from execute.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_fifo.sv | 63 ++++++
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage types and constants, also used by instruction memory and the PC mux.
package fetch_unit_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hBFC00000;
  localparam logic [19:0] WINDOW_TAG   = 20'hBFC00;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } fetch_entry_t;

  typedef enum logic {
    FETCH,
    HALT
  } fetch_state_t;

  function automatic logic fetch_legal(input logic [31:0] addr, input logic [19:0] tag);
    return (addr[31:12] == tag) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory request/return, execute redirects and the decode handshake.
interface fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_fault;

  modport master (
    output imem_addr,
    input  imem_instr,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    output out_fault
  );

  modport slave (
    input  imem_addr,
    output imem_instr,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    input  out_fault
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; push is accepted when full only alongside a pop.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + (AW+1)'(1);
      end else if (do_pop && !do_push) begin
        count <= count - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, fetches one word per cycle into a small FIFO drained by decode,
// and halts after an illegal fetch until execute redirects it.
module fetch_unit
  import fetch_unit_pkg::fetch_entry_t, fetch_unit_pkg::fetch_state_t,
         fetch_unit_pkg::FETCH, fetch_unit_pkg::HALT, fetch_unit_pkg::fetch_legal;
#(
  parameter int          DEPTH        = 2,
  parameter logic [31:0] RESET_VECTOR = fetch_unit_pkg::RESET_VECTOR,
  parameter logic [19:0] WINDOW_TAG   = fetch_unit_pkg::WINDOW_TAG
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t state;
  fetch_state_t state_next;
  logic [31:0]  pc;
  logic [31:0]  pc_next;
  fetch_entry_t push_entry;
  fetch_entry_t head;
  logic         fifo_full;
  logic         fifo_empty;
  logic [AW:0]  unused_count;
  logic         legal;
  logic         out_valid;
  logic         dequeue;
  logic         enqueue;

  assign legal         = fetch_legal(pc, WINDOW_TAG);
  assign out_valid     = !fifo_empty && !bus.redirect_valid;
  assign dequeue       = out_valid && bus.out_ready;
  assign enqueue       = (state == FETCH) && !bus.redirect_valid && (!fifo_full || dequeue);

  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.out_fault = head.fault;

  // A fault entry never carries the memory word, so decode sees a clean zero.
  always_comb begin
    push_entry = '{instr: 32'h0, pc: pc, fault: 1'b1};
    if (legal) begin
      push_entry = '{instr: bus.imem_instr, pc: pc, fault: 1'b0};
    end
  end

  always_comb begin
    state_next = state;
    pc_next    = pc;
    if (bus.redirect_valid) begin
      state_next = FETCH;
      pc_next    = bus.redirect_pc;
    end else if (enqueue) begin
      if (legal) begin
        pc_next = pc + 32'd4;
      end else begin
        state_next = HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH;
      pc    <= RESET_VECTOR;
    end else begin
      state <= state_next;
      pc    <= pc_next;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (enqueue),
    .pop   (dequeue),
    .wdata (push_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (unused_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios plus randomized redirects and back-pressure,
// checked against a queue-based model of the fetch stream.
module tb_fetch_unit;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RV    = 32'hBFC00000;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Combinational instruction memory covering the 4 KiB boot window.
  logic [31:0] imem [1024];
  always_comb begin
    bus.imem_instr = (bus.imem_addr[31:12] == 20'hBFC00) ? imem[bus.imem_addr[11:2]] : 32'hDEADBEEF;
  end

  exp_t        model_q[$];
  logic [31:0] model_pc;
  bit          model_halted;
  int          compared   = 0;
  int          mismatched = 0;

  function automatic bit modelLegal(input logic [31:0] a);
    return (a >= 32'hBFC00000) && (a <= 32'hBFC00FFF) && ((a % 4) == 0);
  endfunction

  function automatic logic [31:0] modelWord(input logic [31:0] a);
    logic [31:0] off;
    logic [9:0]  idx;
    off = (a - RV) / 4;
    idx = off[9:0];
    return imem[idx];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    model_q.delete();
    model_pc     = RV;
    model_halted = 0;
  endtask

  task automatic compareModel(input bit r);
    bit exp_valid;
    exp_valid = (model_q.size() != 0) && !r;
    checkOutput("imem_addr", bus.imem_addr, model_pc);
    checkOutput("out_valid", 32'(bus.out_valid), 32'(exp_valid));
    if (exp_valid) begin
      checkOutput("out_pc", bus.out_pc, model_q[0].pc);
      checkOutput("out_instr", bus.out_instr, model_q[0].instr);
      checkOutput("out_fault", 32'(bus.out_fault), 32'(model_q[0].fault));
    end
  endtask

  task automatic updateModel(input bit r, input logic [31:0] p, input bit rdy);
    bit   deq;
    bit   enq;
    exp_t e;
    if (r) begin
      model_q.delete();
      model_pc     = p;
      model_halted = 0;
    end else begin
      deq = (model_q.size() != 0) && rdy;
      enq = !model_halted && ((model_q.size() < DEPTH) || deq);
      if (deq) void'(model_q.pop_front());
      if (enq) begin
        e.pc = model_pc;
        if (modelLegal(model_pc)) begin
          e.instr  = modelWord(model_pc);
          e.fault  = 1'b0;
          model_pc = model_pc + 32'd4;
        end else begin
          e.instr      = 32'h0;
          e.fault      = 1'b1;
          model_halted = 1;
        end
        model_q.push_back(e);
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic applyStimulus(input bit r, input logic [31:0] p, input bit rdy);
    bus.redirect_valid = r;
    bus.redirect_pc    = p;
    bus.out_ready      = rdy;
    #1;
    compareModel(r);
    @(posedge clk);
    updateModel(r, p, rdy);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] tgt;
    int          kind;

    for (int i = 0; i < 1024; i++) imem[i] = $urandom;
    imem[0] = 32'h00000013;
    imem[1] = 32'h00100093;

    rst                = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.out_ready      = 1'b1;
    #1 rst = 1'b1;
    #3;
    checkOutput("reset imem_addr", bus.imem_addr, RV);
    checkOutput("reset out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset out_pc", bus.out_pc, 32'h0);
    checkOutput("reset out_instr", bus.out_instr, 32'h0);
    checkOutput("reset out_fault", 32'(bus.out_fault), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();

    // First two words stream out one per cycle.
    applyStimulus(0, 32'h0, 1);
    checkOutput("cycle1 out_pc", bus.out_pc, 32'hBFC00000);
    checkOutput("cycle1 out_instr", bus.out_instr, 32'h00000013);
    applyStimulus(0, 32'h0, 1);
    checkOutput("cycle2 out_pc", bus.out_pc, 32'hBFC00004);
    checkOutput("cycle2 out_instr", bus.out_instr, 32'h00100093);

    // Back-pressure saturates the FIFO and freezes the PC.
    for (int i = 0; i < 5; i++) applyStimulus(0, 32'h0, 0);
    checkOutput("stall imem_addr", bus.imem_addr, 32'hBFC0000C);
    checkOutput("stall head pc", bus.out_pc, 32'hBFC00004);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1);
    applyStimulus(0, 32'h0, 0);

    // Redirect while full: old entries are dropped.
    applyStimulus(1, 32'hBFC00100, 1);
    checkOutput("redirect imem_addr", bus.imem_addr, 32'hBFC00100);
    applyStimulus(0, 32'h0, 1);
    checkOutput("redirect out_pc", bus.out_pc, 32'hBFC00100);
    checkOutput("redirect out_valid", 32'(bus.out_valid), 32'h1);

    // Out-of-window target faults, then halts until redirected.
    applyStimulus(1, 32'hBFC01000, 1);
    applyStimulus(0, 32'h0, 1);
    checkOutput("window fault", 32'(bus.out_fault), 32'h1);
    checkOutput("window fault pc", bus.out_pc, 32'hBFC01000);
    checkOutput("window fault instr", bus.out_instr, 32'h0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("halt imem_addr", bus.imem_addr, 32'hBFC01000);
    applyStimulus(1, RV, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1);

    // Misaligned target.
    applyStimulus(1, 32'hBFC00002, 0);
    applyStimulus(0, 32'h0, 0);
    checkOutput("misaligned fault", 32'(bus.out_fault), 32'h1);
    checkOutput("misaligned pc", bus.out_pc, 32'hBFC00002);

    // Running off the end of the window.
    applyStimulus(1, 32'hBFC00FF8, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 1);
    checkOutput("wrap fault pc", bus.out_pc, 32'hBFC01000);
    checkOutput("wrap fault", 32'(bus.out_fault), 32'h1);
    for (int i = 0; i < 2; i++) applyStimulus(0, 32'h0, 1);

    // Asynchronous reset with a full FIFO.
    applyStimulus(1, RV, 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0, 0);
    checkOutput("prereset out_valid", 32'(bus.out_valid), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("async imem_addr", bus.imem_addr, RV);
    checkOutput("async out_pc", bus.out_pc, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus(0, 32'h0, 1);

    // Randomized redirects and back-pressure.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      case (kind)
        0:       tgt = RV + $urandom_range(0, 4095);
        1:       tgt = $urandom;
        2:       tgt = RV + 32'hFF0 + 4 * $urandom_range(0, 3);
        default: tgt = RV + 4 * $urandom_range(0, 1023);
      endcase
      applyStimulus($urandom_range(0, 15) == 0, tgt, $urandom_range(0, 9) < 7);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
